// File: rtl/gen_debounce_edge.sv
// gen_debounce_edge: per-bit debounce filter with rise/fall pulses and sticky event flags.
// Define DEBOUNCE_EDGE_IRQ_EN to enable evt_flag/irq; otherwise they are tied to zero.
module gen_debounce_edge #(
  parameter int DW         = 8,
  parameter int STABLE_CYC = 1000,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  input  logic [DW-1:0] evt_clr,
  output logic [DW-1:0] evt_flag,
  output logic          irq
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);
  logic [DW-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [DW-1:0] dout_d, dout_q, rise_d, rise_q, fall_d, fall_q, evt_flag_d, evt_flag_q;
  logic irq_d, irq_q;
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    for (int i = 0; i < DW; i++) begin
      if (en && din[i] != dout_q[i]) begin
        cnt_d[i]  = (cnt_q[i] >= LAST) ? '0 : cnt_q[i] + 1'b1;
        dout_d[i] = (cnt_q[i] >= LAST) ? din[i] : dout_q[i];
      end
    end
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
`ifdef DEBOUNCE_EDGE_IRQ_EN
    // a pulse landing with a clear keeps the flag set
    evt_flag_d = rise_q | fall_q | (evt_flag_q & ~evt_clr);
`else
    evt_flag_d = evt_clr & '0;
`endif
    irq_d = |evt_flag_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      dout_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      evt_flag_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      evt_flag_q <= evt_flag_d;
      irq_q      <= irq_d;
    end
  end
  assign dout     = dout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign evt_flag = evt_flag_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_gen_debounce_edge.sv
// tb_gen_debounce_edge: directed vectors feed an expected-value queue; a monitor pops and checks each cycle.
module tb_gen_debounce_edge;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [3:0] din = '0;
  logic [3:0] evt_clr = '0;
  logic [3:0] dout, rise, fall, evt_flag;
  logic       irq;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [3:0] d, r, f, g;
  } exp_t;
  exp_t q[$];
  gen_debounce_edge #(.DW(4), .STABLE_CYC(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dout(dout), .rise(rise), .fall(fall),
    .evt_clr(evt_clr), .evt_flag(evt_flag), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic st(input logic r, input logic e, input logic [3:0] d, input logic [3:0] c,
                    input logic [3:0] ed, input logic [3:0] er, input logic [3:0] ef,
                    input logic [3:0] eg, input int n);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r; en = e; din = d; evt_clr = c;
      x.d = ed; x.r = er; x.f = ef;
`ifdef DEBOUNCE_EDGE_IRQ_EN
      x.g = eg;
`else
      x.g = 4'h0;
`endif
      q.push_back(x);
    end
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("dout", dout, x.d);
        chk("rise", rise, x.r);
        chk("fall", fall, x.f);
        chk("rise_and_fall", rise & fall, 4'h0);
        chk("evt_flag", evt_flag, x.g);
        chk("irq", {3'b0, irq}, {3'b0, |x.g});
      end
    end
  end
  initial begin
    int budget;
    st(0,1,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0, 2);
    st(1,1,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0, 2);
    st(1,1,4'h1,4'h0, 4'h0,4'h0,4'h0,4'h0, 3);
    st(1,1,4'h1,4'h0, 4'h1,4'h1,4'h0,4'h0, 1);
    st(1,1,4'h1,4'h0, 4'h1,4'h0,4'h0,4'h1, 1);
    st(1,1,4'h1,4'h1, 4'h1,4'h0,4'h0,4'h0, 1);
    st(1,1,4'h3,4'h0, 4'h1,4'h0,4'h0,4'h0, 3);
    st(1,1,4'h1,4'h0, 4'h1,4'h0,4'h0,4'h0, 1);
    st(1,1,4'h3,4'h0, 4'h1,4'h0,4'h0,4'h0, 3);
    st(1,1,4'h3,4'h0, 4'h3,4'h2,4'h0,4'h0, 1);
    st(1,1,4'h3,4'h0, 4'h3,4'h0,4'h0,4'h2, 1);
    st(1,1,4'h3,4'h2, 4'h3,4'h0,4'h0,4'h0, 1);
    st(1,0,4'hF,4'h0, 4'h3,4'h0,4'h0,4'h0, 10);
    st(1,1,4'hF,4'h0, 4'h3,4'h0,4'h0,4'h0, 3);
    st(1,1,4'hF,4'h0, 4'hF,4'hC,4'h0,4'h0, 1);
    st(1,1,4'hF,4'h0, 4'hF,4'h0,4'h0,4'hC, 1);
    st(1,1,4'hF,4'hF, 4'hF,4'h0,4'h0,4'h0, 1);
    st(1,1,4'hB,4'h0, 4'hF,4'h0,4'h0,4'h0, 3);
    st(1,1,4'hB,4'h0, 4'hB,4'h0,4'h4,4'h0, 1);
    st(1,1,4'hB,4'h4, 4'hB,4'h0,4'h0,4'h4, 1);
    st(1,1,4'hB,4'h4, 4'hB,4'h0,4'h0,4'h0, 1);
    st(1,1,4'hF,4'h0, 4'hB,4'h0,4'h0,4'h0, 2);
    st(0,1,4'hF,4'h0, 4'h0,4'h0,4'h0,4'h0, 1);
    st(1,1,4'hF,4'h0, 4'h0,4'h0,4'h0,4'h0, 3);
    st(1,1,4'hF,4'h0, 4'hF,4'hF,4'h0,4'h0, 1);
    st(1,1,4'hF,4'h0, 4'hF,4'h0,4'h0,4'hF, 1);
    st(1,1,4'hF,4'hF, 4'hF,4'h0,4'h0,4'h0, 1);
    st(1,1,4'h7,4'h0, 4'hF,4'h0,4'h0,4'h0, 3);
    st(1,1,4'h7,4'h0, 4'h7,4'h0,4'h8,4'h0, 1);
    st(1,1,4'h7,4'h0, 4'h7,4'h0,4'h0,4'h8, 1);
    st(1,1,4'h7,4'h8, 4'h7,4'h0,4'h0,4'h0, 1);
    st(1,1,4'hF,4'h0, 4'h7,4'h0,4'h0,4'h0, 3);
    st(1,1,4'hF,4'h0, 4'hF,4'h8,4'h0,4'h0, 1);
    st(1,1,4'hF,4'h0, 4'hF,4'h0,4'h0,4'h8, 1);
    st(1,1,4'h7,4'h0, 4'hF,4'h0,4'h0,4'h8, 3);
    st(1,1,4'h7,4'h0, 4'h7,4'h0,4'h8,4'h8, 1);
    st(1,1,4'h7,4'h8, 4'h7,4'h0,4'h0,4'h8, 1);
    st(1,1,4'h7,4'h8, 4'h7,4'h0,4'h0,4'h0, 1);
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gen_debounce_edge.md
GEN_DEBOUNCE_EDGE -- requirements
Module: gen_debounce_edge

Interface
REQ-001 SHALL have parameter DW, default 8, number of independent input bits.
REQ-002 SHALL have parameter STABLE_CYC, default 1000, consecutive differing samples needed to accept a level change; legal range 1..2^CNT_W.
REQ-003 SHALL have parameter CNT_W, default 16, per-bit counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  filter enable.
REQ-007 SHALL have port din  input  DW  already-synchronized input bits, driven by the 2-stage synchronizer output.
REQ-008 SHALL have port dout  output  DW  debounced level, registered.
REQ-009 SHALL have port rise  output  DW  one-cycle pulse per bit when dout goes 0->1.
REQ-010 SHALL have port fall  output  DW  one-cycle pulse per bit when dout goes 1->0.
REQ-011 SHALL have port evt_clr  input  DW  write-1-to-clear for event flags.
REQ-012 SHALL have port evt_flag  output  DW  sticky edge-event flags.
REQ-013 SHALL have port irq  output  1  OR of evt_flag.

Function
REQ-014 SHALL process each bit i independently using counter cnt[i] (CNT_W bits), compared against dout[i].
REQ-015 SHALL, when en=1 and din[i]==dout[i], load cnt[i] with 0; any glitch restarts the count.
REQ-016 SHALL, when en=1, din[i]!=dout[i] and cnt[i]<STABLE_CYC-1, increment cnt[i].
REQ-017 SHALL, when en=1, din[i]!=dout[i] and cnt[i]==STABLE_CYC-1, load dout[i]<=din[i] and cnt[i]<=0 on that edge.
REQ-018 Latency: a change held on STABLE_CYC consecutive sampling edges SHALL appear on dout at the STABLE_CYC-th edge; STABLE_CYC=1 gives dout = din delayed one cycle.
REQ-019 SHALL assert rise[i] (or fall[i]) in exactly the cycle dout[i] first shows its new value, registered, for one cycle; never both at once.
REQ-020 SHALL, when en=0, clear all counters, hold dout, and drive rise=fall=0.
REQ-021 SHALL never wrap cnt[i]; it cannot exceed STABLE_CYC-1.
REQ-022 SHALL change multiple bits in the same cycle independently, with no interaction.

Reset
REQ-023 SHALL, while rst=0, immediately force dout=0, cnt=0, rise=0, fall=0, evt_flag=0, irq=0.
REQ-024 SHALL, on rst deassertion, resume counting from zero; input high at release SHALL produce rise only after STABLE_CYC edges.
REQ-025 SHALL discard any partial count when reset is asserted mid-count.

Configuration
REQ-026 With macro DEBOUNCE_EDGE_IRQ_EN defined, evt_flag[i] SHALL set on rise[i] or fall[i] (one cycle after the pulse), SHALL clear on evt_clr[i]=1, set wins over simultaneous clear; irq SHALL be registered |evt_flag.
REQ-027 Without DEBOUNCE_EDGE_IRQ_EN, ports SHALL remain, evt_flag=0 and irq=0 constantly, and evt_clr SHALL be ignored.

Verification (DW=4, STABLE_CYC=4)
REQ-028 din[0] 0->1 held -> dout[0]=1 and rise[0]=1 at 4th edge after change, rise low next cycle.
REQ-029 din[1] high 3 cycles, low 1, high 4 -> no change during first burst; dout[1]=1 on 4th edge of second burst.
REQ-030 en=0 while din=4'hF for 10 cycles, then en=1 -> dout stays 0 until 4 edges after en rises.
REQ-031 rst pulled low after 2 counts of din[2]=1, released with din held -> dout[2] updates 4 edges after release, not 2.
REQ-032 Macro defined: rise[3] -> evt_flag[3]=1, irq=1; evt_clr=4'h8 coinciding with a new fall[3] -> flag stays 1; evt_clr alone -> flag 0, irq 0.
REQ-033 Macro undefined: same stimulus as REQ-032 -> evt_flag=0, irq=0 throughout; dout/rise/fall identical.
